// File: rtl/mem_req_adapter.sv
// ---------------------------------------------------------------------------
// mem_req_adapter
//   Memory-side stage behind the frame controller. It converts the
//   req/rd_wr/tem_win/row/col/wr_index/write_data request stream into
//   word-addressed Avalon-style read/write transactions. Read data comes back
//   with a one-cycle read_valid pulse, and a write completion gives a
//   one-cycle wr_done pulse. The block counts frames via set_done. It aborts a
//   read that never returns data after TIMEOUT cycles.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req, rd_wr          request strobe, 0 = read / 1 = write
//   tem_win             read region select, 0 = template / 1 = window
//   row, col            image coordinates for reads
//   wr_index            result word 0..2 within a set (3 is illegal)
//   write_data          write payload
//   set_count           set index used for result addressing
//   set_done            end-of-frame pulse, increments frame_count
//   busy                high while a transaction is in flight
//   read_data/read_valid returned word and its one-cycle valid pulse
//   wr_done             one-cycle write-complete pulse
//   err                 sticky error (illegal wr_index or read timeout)
//   frame_count         completed frames, wraps
//   mem_*               Avalon-style memory master port
//
// Optional feature
//   `define MEM_REQ_PINGPONG_EN selects the result bank from frame_count[0],
//   adding RESULT_BANK_OFFSET on odd frames. Without the macro, results always
//   go to RESULT_BASE.
// ---------------------------------------------------------------------------
module mem_req_adapter #(
    parameter int                 ADDR_W             = 24,
    parameter int                 ROW_STRIDE         = 128,
    parameter logic [ADDR_W-1:0]  TEMPLATE_BASE      = 24'h000000,
    parameter logic [ADDR_W-1:0]  WINDOW_BASE        = 24'h004000,
    parameter logic [ADDR_W-1:0]  RESULT_BASE        = 24'h008000,
    parameter logic [ADDR_W-1:0]  RESULT_BANK_OFFSET = 24'h001000,
    parameter int                 TIMEOUT            = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              rd_wr,
    input  logic              tem_win,
    input  logic [6:0]        row,
    input  logic [6:0]        col,
    input  logic [1:0]        wr_index,
    input  logic [31:0]       write_data,
    input  logic [7:0]        set_count,
    input  logic              set_done,
    output logic              busy,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              wr_done,
    output logic              err,
    output logic [7:0]        frame_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rvalid,
    input  logic              mem_waitrequest
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_t;

    // The abort fires on the cycle the counter would reach TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [7:0]        tmo_cnt_r;
    logic [7:0]        tmo_cnt_s;

    logic              rd_accept_s;
    logic              wr_accept_s;
    logic              wr_bad_s;
    logic              rsp_ok_s;
    logic              tmo_abort_s;
    logic              bank_sel_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] wr_addr_s;

    logic              busy_s;
    logic [31:0]       read_data_s;
    logic              read_valid_s;
    logic              wr_done_s;
    logic              err_s;
    logic [7:0]        frame_count_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              mem_rd_s;
    logic              mem_wr_s;
    logic [31:0]       mem_wdata_s;

`ifdef MEM_REQ_PINGPONG_EN
    // The current (pre-increment) frame parity selects the result bank.
    assign bank_sel_s = frame_count[0];
`else
    assign bank_sel_s = 1'b0;
`endif

    // Decode request acceptance, response completion and address arithmetic.
    always_comb begin
        rd_accept_s = (state_r == IDLE) && req && !rd_wr;
        wr_accept_s = (state_r == IDLE) && req && rd_wr && (wr_index != 2'd3);
        wr_bad_s    = (state_r == IDLE) && req && rd_wr && (wr_index == 2'd3);
        // A zero-wait accept can see rvalid in the same cycle.
        rsp_ok_s    = ((state_r == RD_ISSUE) && !mem_waitrequest && mem_rvalid) ||
                      ((state_r == RD_WAIT) && mem_rvalid);
        tmo_abort_s = (state_r == RD_WAIT) && !mem_rvalid && (tmo_cnt_r == TMO_LAST);
        rd_addr_s   = (tem_win ? WINDOW_BASE : TEMPLATE_BASE)
                      + ADDR_W'(row) * ADDR_W'(ROW_STRIDE) + ADDR_W'(col);
        wr_addr_s   = RESULT_BASE + (bank_sel_s ? RESULT_BANK_OFFSET : {ADDR_W{1'b0}})
                      + ADDR_W'(set_count) * ADDR_W'(3) + ADDR_W'(wr_index);
    end

    // State register and read-timeout counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            tmo_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_next_s;
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rd_accept_s) begin
                    state_next_s = RD_ISSUE;
                end else if (wr_accept_s) begin
                    state_next_s = WR_ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_ISSUE: begin
                if (mem_waitrequest) begin
                    state_next_s = RD_ISSUE;
                end else if (mem_rvalid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (rsp_ok_s || tmo_abort_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RD_WAIT;
                end
            end
            WR_ISSUE: begin
                if (mem_waitrequest) begin
                    state_next_s = WR_ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: next values for every registered output.
    always_comb begin
        busy_s        = (state_next_s != IDLE);
        mem_rd_s      = (state_next_s == RD_ISSUE);
        mem_wr_s      = (state_next_s == WR_ISSUE);
        read_valid_s  = rsp_ok_s || tmo_abort_s;
        wr_done_s     = ((state_r == WR_ISSUE) && !mem_waitrequest) || wr_bad_s;
        err_s         = err || tmo_abort_s || wr_bad_s;
        frame_count_s = frame_count + {7'd0, set_done};
        // The counter only advances on empty RD_WAIT cycles and restarts on exit.
        if ((state_r == RD_WAIT) && !mem_rvalid && !tmo_abort_s) begin
            tmo_cnt_s = tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_s = 8'd0;
        end
        if (rsp_ok_s) begin
            read_data_s = mem_rdata;
        end else if (tmo_abort_s) begin
            read_data_s = 32'hDEADBEEF;
        end else begin
            read_data_s = read_data;
        end
        if (rd_accept_s) begin
            mem_addr_s  = rd_addr_s;
            mem_wdata_s = mem_wdata;
        end else if (wr_accept_s) begin
            mem_addr_s  = wr_addr_s;
            mem_wdata_s = write_data;
        end else begin
            mem_addr_s  = mem_addr;
            mem_wdata_s = mem_wdata;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            read_data   <= 32'd0;
            read_valid  <= 1'b0;
            wr_done     <= 1'b0;
            err         <= 1'b0;
            frame_count <= 8'd0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= 32'd0;
        end else begin
            busy        <= busy_s;
            read_data   <= read_data_s;
            read_valid  <= read_valid_s;
            wr_done     <= wr_done_s;
            err         <= err_s;
            frame_count <= frame_count_s;
            mem_addr    <= mem_addr_s;
            mem_rd      <= mem_rd_s;
            mem_wr      <= mem_wr_s;
            mem_wdata   <= mem_wdata_s;
        end
    end

endmodule

// File: doc/mem_req_adapter.md
Name: mem_req_adapter

Overview:
- Memory-side stage directly downstream of the frame controller (user FPGA format block).
- Converts its req/rd_wr/tem_win/row/col/wr_index/write_data request stream into word-addressed transactions on an Avalon-style memory port.
- Returns read data with an explicit valid pulse, and exposes busy so the controller and handlers can stall.
- Tracks frames via set_done and guards against a hung memory with a read timeout.

Parameters:
- ADDR_W, 24, memory word-address width; every address is computed modulo 2^ADDR_W.
- ROW_STRIDE, 128, words per image row for template/window addressing.
- TEMPLATE_BASE, 24'h000000, template region word base.
- WINDOW_BASE, 24'h004000, window region word base.
- RESULT_BASE, 24'h008000, result region word base; 3 words per set.
- RESULT_BANK_OFFSET, 24'h001000, second result bank offset (optional feature only).
- TIMEOUT, 255, maximum cycles in RD_WAIT before abort; 8-bit counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- req  in  1  controller wants memory
- rd_wr  in  1  0 = read, 1 = write
- tem_win  in  1  0 = template region, 1 = window region (reads only)
- row  in  7  row index
- col  in  7  column index
- wr_index  in  2  result word 0..2 within a set
- write_data  in  32  write payload
- set_count  in  8  completed-set index used for result addressing
- set_done  in  1  one-cycle end-of-frame pulse
- busy  out  1  high when a request cannot be accepted
- read_data  out  32  returned word; holds until the next read completes
- read_valid  out  1  one-cycle pulse, read_data valid
- wr_done  out  1  one-cycle pulse, write accepted by memory
- err  out  1  sticky error flag
- frame_count  out  8  frames completed, wraps 255->0
- mem_addr  out  ADDR_W  memory word address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_rvalid  in  1  read data valid
- mem_waitrequest  in  1  memory stall; strobe must be held while high

Behaviour:
- Reset: every output 0; state IDLE; timeout counter 0. Reset mid-transaction abandons it; mem_rd/mem_wr are low from the first cycle after the reset edge; no read_valid or wr_done pulse is issued.
- All outputs are registered.
- busy = (state != IDLE).
- Request acceptance: req && state==IDLE. Address and data are captured at that edge; the request is removed from the controller's perspective.
- Read address:
  - tem_win=0: TEMPLATE_BASE + row*ROW_STRIDE + col.
  - tem_win=1: WINDOW_BASE + row*ROW_STRIDE + col.
- Write address: result base + set_count*3 + wr_index. Result base is RESULT_BASE, or as selected by the optional feature.
- Invalid write: wr_index==3 on a write sets err; the request is consumed; no memory cycle is issued; wr_done is still pulsed.
- IDLE:
  - Accepted read -> RD_ISSUE; mem_rd=1 on the next cycle.
  - Accepted valid write -> WR_ISSUE; mem_wr=1 and mem_wdata driven on the next cycle.
- RD_ISSUE:
  - Hold mem_rd and mem_addr while mem_waitrequest=1.
  - When mem_waitrequest=0: drop mem_rd next cycle and go to RD_WAIT.
  - If mem_rvalid=1 in the same cycle, complete directly (as in RD_WAIT).
- RD_WAIT:
  - On mem_rvalid: read_data<=mem_rdata and read_valid=1 on the next cycle; go to IDLE.
  - Each cycle without rvalid increments the counter. Reaching TIMEOUT: read_data<=32'hDEADBEEF, read_valid pulse, err<=1, go to IDLE.
  - A late rvalid seen in IDLE is ignored.
- WR_ISSUE: hold mem_wr/addr/wdata while mem_waitrequest=1. On waitrequest=0: wr_done pulse next cycle; go to IDLE.
- Minimum latency:
  - Read: req edge -> mem_rd at +1 -> read_valid at +3 (zero-wait memory, rvalid one cycle after accept).
  - Write: wr_done at +2.
- set_done: frame_count increments on every pulse, independent of state. If coincident with req, both take effect.
- err clears only on reset.

Optional Feature:
- Macro: MEM_REQ_PINGPONG_EN.
- Defined: result base = RESULT_BASE + (frame_count[0] ? RESULT_BANK_OFFSET : 0). A write issued in the same cycle set_done increments frame_count uses the pre-increment bank.
- Undefined: result base is always RESULT_BASE; frame_count still counts.

Test Plan:
- Template read, row=2 col=5, zero-wait memory, mem_rdata=32'hA5A5_0001 -> mem_addr=24'h000105; read_valid at +3 with read_data=32'hA5A5_0001; busy high cycles +1..+2.
- Window read, row=1 col=0, mem_waitrequest high 4 cycles -> mem_addr=24'h004080 with mem_rd held stable all 4 cycles; then single read_valid.
- Write, set_count=10 wr_index=2 write_data=32'h1234_5678 -> mem_addr=24'h008020, mem_wdata=32'h1234_5678, wr_done pulse; wr_index=3 -> no mem_wr, err=1.
- Read with mem_rvalid never asserted -> after 255 cycles read_data=32'hDEADBEEF, read_valid=1, err=1; a subsequent read completes normally.
- rst_n low during RD_WAIT -> mem_rd=0, busy=0, read_valid=0, err=0, frame_count=0 after the reset edge.
- With MEM_REQ_PINGPONG_EN: one set_done pulse, then write set_count=0 wr_index=0 -> mem_addr=24'h009000. Without the macro -> 24'h008000.
